// File: rtl/fc_pkg.sv
// Shared types and default sizes for the fully-connected output streamer.
package fc_pkg;

    localparam int FC_WIDTH = 8;
    localparam int FC_IN    = 400;
    localparam int FC_ACC_W = FC_WIDTH * 2 + $clog2(FC_IN);
    localparam int FC_N_OUT = 84;
    localparam int FC_SHIFT = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    typedef logic [FC_ACC_W-1:0] acc_t;
    typedef logic [FC_WIDTH-1:0] act_t;

endpackage

// File: rtl/fc_out_streamer_requant_sat.sv
// Requantizes one signed accumulator to an unsigned activation:
// arithmetic right shift, negatives clamp to 0, overflow clamps to all-ones.
module requant_sat #(
    parameter int ACC_W = 25,
    parameter int WIDTH = 8,
    parameter int SHIFT = 4
) (
    input  logic [ACC_W-1:0] acc,
    output logic [WIDTH-1:0] act
);

    logic signed [ACC_W-1:0] q;

    assign q = $signed(acc) >>> SHIFT;

    // Once the sign bit is known clear, any set bit above WIDTH means overflow.
    always_comb begin
        act = q[WIDTH-1:0];
        if (q[ACC_W-1]) begin
            act = '0;
        end else if (|q[ACC_W-1:WIDTH]) begin
            act = '1;
        end
    end

endmodule

// File: rtl/fc_out_streamer.sv
// Captures a full frame of neuron accumulators in one handshake and streams
// the requantized activations one per beat, index 0 first, with no bubbles.
module fc_out_streamer
    import fc_pkg::*;
#(
    parameter int WIDTH = FC_WIDTH,
    parameter int IN    = FC_IN,
    parameter int ACC_W = WIDTH * 2 + $clog2(IN),
    parameter int N_OUT = FC_N_OUT,
    parameter int SHIFT = FC_SHIFT,
    localparam int IDX_W = $clog2(N_OUT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ACC_W-1:0] in_data [0:N_OUT-1],
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OUT - 1);

    // valid/ready: a transfer happens on a rising edge where both are high;
    // while valid is high and ready is low the offered element holds stable.

    state_t           state;
    state_t           state_next;
    logic [ACC_W-1:0] frame [0:N_OUT-1];
    logic [ACC_W-1:0] sel_acc;
    logic [WIDTH-1:0] sel_act;
    logic [IDX_W-1:0] idx_next;
    logic             capture;
    logic             beat;
    logic             final_beat;

    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == STREAM);
    assign busy       = (state == STREAM);
    assign out_last   = out_valid && (out_idx == LAST_IDX);
    assign capture    = in_valid && in_ready;
    assign beat       = out_valid && out_ready;
    assign final_beat = beat && out_last;

    // The single requantizer sees element 0 of the incoming frame at capture,
    // otherwise the buffered element the next beat will present.
    always_comb begin
        state_next = state;
        idx_next   = out_idx;
        sel_acc    = in_data[0];
        case (state)
            IDLE: begin
                if (capture) begin
                    state_next = STREAM;
                    idx_next   = '0;
                end
            end
            STREAM: begin
                if (final_beat) begin
                    state_next = IDLE;
                    idx_next   = '0;
                end else if (beat) begin
                    idx_next = out_idx + IDX_W'(1);
                    sel_acc  = frame[idx_next];
                end
            end
            default: state_next = IDLE;
        endcase
    end

    requant_sat #(
        .ACC_W(ACC_W),
        .WIDTH(WIDTH),
        .SHIFT(SHIFT)
    ) u_requant (
        .acc(sel_acc),
        .act(sel_act)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            out_idx  <= '0;
            out_data <= '0;
        end else begin
            state   <= state_next;
            out_idx <= idx_next;
            if (final_beat) begin
                out_data <= '0;
            end else if (capture || beat) begin
                out_data <= sel_act;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            frame <= in_data;
        end
    end

endmodule

// File: tb/tb_fc_out_streamer.sv
// Self-checking bench for fc_out_streamer: table vectors, timed hand sequences
// and random frames scored against an arithmetic requantization model.
module tb_fc_out_streamer;

    localparam int W     = 8;
    localparam int IN    = 400;
    localparam int ACC_W = W * 2 + $clog2(IN);
    localparam int N     = 84;
    localparam int SH    = 4;
    localparam int IW    = $clog2(N);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [ACC_W-1:0] in_data [0:N-1];
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic [IW-1:0] out_idx;
    logic          out_last;
    logic          busy;

    int n_checks = 0;
    int n_err    = 0;
    logic [IW+W-1:0] exp_q [$];

    typedef struct {
        logic [ACC_W-1:0] acc;
        logic [W-1:0]     exp;
    } vec_t;
    vec_t vec [12];

    always #5 clk = ~clk;

    fc_out_streamer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx), .out_last(out_last), .busy(busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Floor division by 2^SH, then clamp into the unsigned activation range.
    function automatic logic [W-1:0] model(input logic [ACC_W-1:0] a);
        longint v, d, q;
        v = longint'($signed(a));
        d = longint'(1) << SH;
        if (v >= 0) q = v / d;
        else q = -((-v + d - 1) / d);
        if (q < 0) return '0;
        if (q > (longint'(1) << W) - 1) return '1;
        return q[W-1:0];
    endfunction

    function automatic logic [ACC_W-1:0] rand_acc();
        case ($urandom_range(0, 4))
            0: return ACC_W'($urandom_range(0, 4095));
            1: return ACC_W'($urandom_range(4064, 4127));
            2: return ACC_W'($urandom_range(0, (1 << (ACC_W - 1)) - 1));
            3: return ACC_W'(-int'($urandom_range(1, 100000)));
            default: return ACC_W'($urandom_range(0, 31));
        endcase
    endfunction

    task automatic push_model();
        for (int i = 0; i < N; i++) exp_q.push_back({IW'(i), model(in_data[i])});
    endtask

    task automatic capture();
        check("cap_in_ready", in_ready, 1);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Called at a negedge with a captured frame on offer; consumes n beats.
    task automatic stream(input int mode, input int n);
        int got = 0;
        int cyc = 0;
        logic pv = 1'b0;
        logic prdy = 1'b0;
        logic [W-1:0] pd = '0;
        logic [IW-1:0] pi = '0;
        bit pat [6] = '{1, 0, 0, 1, 0, 1};
        logic [IW+W-1:0] e;
        while (got < n && cyc < 4000) begin
            check("stream_valid", out_valid, 1);
            check("stream_busy", busy, 1);
            if (exp_q.size() > 0) begin
                e = exp_q[0];
                check("last", out_last, e[IW+W-1:W] == IW'(N - 1));
            end
            if (pv && !prdy) begin
                check("hold_data", out_data, pd);
                check("hold_idx", out_idx, pi);
            end
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = pat[cyc % 6];
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (out_valid && out_ready && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("beat_idx", out_idx, e[IW+W-1:W]);
                check("beat_data", out_data, e[W-1:0]);
                got++;
            end
            pv = out_valid; prdy = out_ready; pd = out_data; pi = out_idx;
            @(negedge clk);
            cyc++;
        end
        if (got < n) check("stream_timeout", got, n);
    endtask

    task automatic check_idle();
        check("idle_valid", out_valid, 0);
        check("idle_last", out_last, 0);
        check("idle_busy", busy, 0);
        check("idle_in_ready", in_ready, 1);
    endtask

    initial begin
        for (int i = 0; i < N; i++) in_data[i] = '0;

        // Reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_last", out_last, 0);
        check("rst_idx", out_idx, 0);
        check("rst_data", out_data, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);

        // Full-rate frame with exact cycle timing
        for (int i = 0; i < N; i++) in_data[i] = ACC_W'(i * 16);
        out_ready = 1'b1;
        capture();
        for (int k = 0; k < N; k++) begin
            check("fr_valid", out_valid, 1);
            check("fr_idx", out_idx, k);
            check("fr_data", out_data, k);
            check("fr_last", out_last, k == N - 1);
            check("fr_in_ready", in_ready, 0);
            @(negedge clk);
        end
        check_idle();
        out_ready = 1'b0;

        // Requantization table
        vec[0]  = '{ACC_W'(16), 8'd1};
        vec[1]  = '{ACC_W'(15), 8'd0};
        vec[2]  = '{ACC_W'(4080), 8'd255};
        vec[3]  = '{ACC_W'(4095), 8'd255};
        vec[4]  = '{ACC_W'(4096), 8'd255};
        vec[5]  = '{ACC_W'(-16), 8'd0};
        vec[6]  = '{ACC_W'(0), 8'd0};
        vec[7]  = '{ACC_W'(-1), 8'd0};
        vec[8]  = '{ACC_W'(17), 8'd1};
        vec[9]  = '{ACC_W'(4079), 8'd254};
        vec[10] = '{ACC_W'((1 << (ACC_W - 1)) - 1), 8'd255};
        vec[11] = '{ACC_W'(-(1 << (ACC_W - 1))), 8'd0};
        for (int i = 0; i < N; i++) in_data[i] = '0;
        for (int k = 0; k < 12; k++) in_data[k] = vec[k].acc;
        for (int i = 0; i < N; i++)
            exp_q.push_back({IW'(i), (i < 12) ? vec[i].exp : W'(0)});
        capture();
        stream(0, N);
        check_idle();

        // Backpressure pattern 1,0,0,1,0,1
        for (int i = 0; i < N; i++) in_data[i] = rand_acc();
        push_model();
        capture();
        stream(1, N);
        check_idle();

        // Overlap: in_valid held high, second frame waits for the drain
        for (int i = 0; i < N; i++) in_data[i] = rand_acc();
        push_model();
        out_ready = 1'b1;
        check("ov_in_ready", in_ready, 1);
        in_valid = 1'b1;
        @(negedge clk);
        for (int i = 0; i < N; i++) in_data[i] = rand_acc();
        stream(0, N);
        check_idle();
        @(negedge clk);
        in_valid = 1'b0;
        check("ov_second_valid", out_valid, 1);
        check("ov_second_idx", out_idx, 0);
        check("ov_second_data", out_data, model(in_data[0]));
        push_model();
        stream(2, N);
        check_idle();

        // Reset mid-stream at idx 40
        for (int i = 0; i < N; i++) in_data[i] = rand_acc();
        push_model();
        capture();
        stream(0, 40);
        check("mid_idx", out_idx, 40);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        check("mid_valid", out_valid, 0);
        check("mid_idx0", out_idx, 0);
        check("mid_data0", out_data, 0);
        for (int k = 0; k < 5; k++) begin
            check_idle();
            @(negedge clk);
        end
        for (int i = 0; i < N; i++) in_data[i] = rand_acc();
        push_model();
        capture();
        stream(2, N);
        check_idle();

        // Random frames with random backpressure
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < N; i++) in_data[i] = rand_acc();
            push_model();
            out_ready = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            capture();
            stream(2, N);
            check_idle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
